// File: rtl/rr_thread_scheduler.sv
// ---------------------------------------------------------------------------
// rr_thread_scheduler
//
// Round-robin thread scheduler. Each cycle it picks one eligible thread
// (active and not stalled) and offers it to fetch/issue over a registered
// valid/ready handshake. Threads can be stalled for a programmable number
// of cycles to cover long-latency operations.
//
// Optional build macro: SCHED_QUANTUM_EN
//   When defined, a thread may issue up to QUANTUM times back-to-back
//   before the rotation moves on. When undefined, rotation is strict.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-low reset
//   active_threads  in   bit i = thread i alive
//   stall_req       in   load stall counter of stall_id this cycle
//   stall_id        in   thread to stall
//   stall_cycles    in   stall length in cycles (0 = no effect)
//   issue_ready     in   downstream accepts issue_thread
//   issue_valid     out  issue_thread is valid
//   issue_thread    out  scheduled thread ID
//   stalled_threads out  bit i = stall counter i nonzero
//   all_done        out  no active threads and nothing pending
// ---------------------------------------------------------------------------
module rr_thread_scheduler #(
  parameter int NUM_THREADS     = 4,
  parameter int THREAD_ID_WIDTH = 3,
  parameter int STALL_WIDTH     = 4,
  parameter int QUANTUM         = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_THREADS-1:0]     active_threads,
  input  logic                       stall_req,
  input  logic [THREAD_ID_WIDTH-1:0] stall_id,
  input  logic [STALL_WIDTH-1:0]     stall_cycles,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [THREAD_ID_WIDTH-1:0] issue_thread,
  output logic [NUM_THREADS-1:0]     stalled_threads,
  output logic                       all_done
);

  localparam logic [THREAD_ID_WIDTH-1:0] LAST_THREAD = THREAD_ID_WIDTH'(NUM_THREADS - 1);

  logic [STALL_WIDTH-1:0]     stall_cnt [NUM_THREADS];
  logic [THREAD_ID_WIDTH-1:0] last_id;
  logic [NUM_THREADS-1:0]     elig;
  logic [NUM_THREADS-1:0]     stall_load;
  logic                       last_elig;
  logic                       free;
  logic [THREAD_ID_WIDTH-1:0] next_start;
  logic [THREAD_ID_WIDTH-1:0] search_start;
  logic                       pick_found;
  logic [THREAD_ID_WIDTH-1:0] pick_id;

`ifdef SCHED_QUANTUM_EN
  localparam int RUN_W = $clog2(QUANTUM + 1);
  logic [RUN_W-1:0] run_cnt;
`else
  // QUANTUM only matters when the quantum extension is built in.
  logic unused_quantum;
  assign unused_quantum = ^QUANTUM;
`endif

  assign free       = !issue_valid || issue_ready;
  assign next_start = (last_id == LAST_THREAD) ? '0 : last_id + THREAD_ID_WIDTH'(1);

  // Eligibility and stall-load decode. A thread being stalled this cycle is
  // already excluded so it can never be picked in its request cycle.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    elig            = '0;
    stall_load      = '0;
    stalled_threads = '0;
    last_elig       = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      stall_load[i]      = stall_req && (stall_cycles != '0) &&
                           (stall_id == THREAD_ID_WIDTH'(i));
      elig[i]            = active_threads[i] && (stall_cnt[i] == '0) && !stall_load[i];
      stalled_threads[i] = (stall_cnt[i] != '0);
      if (last_id == THREAD_ID_WIDTH'(i)) begin
        last_elig = elig[i];
      end
    end
  end

  // Where the wrapped search begins.
  always_comb begin
    search_start = next_start;
`ifdef SCHED_QUANTUM_EN
    // run_cnt == 0 means nothing has issued since reset, so last_id is only
    // the rotation seed and must not be given a quantum.
    if ((run_cnt != '0) && (run_cnt < RUN_W'(QUANTUM)) && last_elig) begin
      search_start = last_id;
    end
`endif
  end

  // Wrapped first-set search: first take the lowest eligible id at or above
  // search_start; if none, the lowest eligible id overall is next in order.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!pick_found && elig[i] && (THREAD_ID_WIDTH'(i) >= search_start)) begin
        pick_found = 1'b1;
        pick_id    = THREAD_ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!pick_found && elig[i]) begin
        pick_found = 1'b1;
        pick_id    = THREAD_ID_WIDTH'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_valid  <= 1'b0;
      issue_thread <= '0;
      all_done     <= 1'b0;
      last_id      <= LAST_THREAD;
      // NOTE: the stall counters are a small register array, not a RAM; they
      // must be reset because they gate eligibility from the first cycle.
      for (int i = 0; i < NUM_THREADS; i++) begin
        stall_cnt[i] <= '0;
      end
`ifdef SCHED_QUANTUM_EN
      run_cnt <= '0;
`endif
    end else begin
      // A fresh load wins over the decrement and overwrites any count.
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (stall_load[i]) begin
          stall_cnt[i] <= stall_cycles;
        end else if (stall_cnt[i] != '0) begin
          stall_cnt[i] <= stall_cnt[i] - STALL_WIDTH'(1);
        end
      end

      // A held offer stays put until accepted, even if its thread goes away.
      if (free) begin
        if (pick_found) begin
          issue_valid  <= 1'b1;
          issue_thread <= pick_id;
          last_id      <= pick_id;
`ifdef SCHED_QUANTUM_EN
          if ((pick_id == last_id) && (run_cnt != '0)) begin
            if (run_cnt < RUN_W'(QUANTUM)) begin
              run_cnt <= run_cnt + RUN_W'(1);
            end
          end else begin
            run_cnt <= RUN_W'(1);
          end
`endif
        end else begin
          issue_valid <= 1'b0;
        end
      end

      all_done <= (active_threads == '0) && !issue_valid;
    end
  end

endmodule
